// File: rtl/load_sched8.sv
// load_sched8: steers accepted stream words into free slots of an 8-slot bank, tracking occupancy
module load_sched8 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_addr_en,
    input  logic [2:0]       in_addr,
    output logic [7:0]       load,
    output logic [2:0]       sel,
    output logic [WIDTH-1:0] data_out,
    output logic [7:0]       full,
    input  logic [7:0]       drain,
    output logic [3:0]       count
);
    logic [2:0] ptr, rr_target, target;
    logic       accept;
    logic [7:0] set_mask, full_nx;
    always_comb begin
        rr_target = ptr;
        for (int k = 7; k >= 0; k--)
            if (!full[3'(ptr + 3'(k))]) rr_target = 3'(ptr + 3'(k));
    end
    assign in_ready = in_addr_en ? !full[in_addr] : (full != 8'hFF);
    assign accept   = in_valid && in_ready;
    assign target   = in_addr_en ? in_addr : rr_target;
    assign set_mask = {7'd0, accept} << target;
    assign full_nx  = (full & ~drain) | set_mask;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            full     <= '0;
            count    <= '0;
            load     <= '0;
            sel      <= '0;
            data_out <= '0;
        end else begin
            ptr   <= (accept && !in_addr_en) ? rr_target + 3'd1 : ptr;
            full  <= full_nx;
            count <= 4'($countones(full_nx));
            load  <= set_mask;
            if (accept) begin
                sel      <= target;
                data_out <= in_data;
            end
        end
    end
endmodule

// File: tb/tb_load_sched8.sv
// tb_load_sched8: table-driven vectors plus scoreboard for load_sched8
module tb_load_sched8;
    logic        clk = 0, reset = 1;
    logic        in_valid = 0, in_ready, in_addr_en = 0;
    logic [15:0] in_data = '0, data_out;
    logic [2:0]  in_addr = '0, sel;
    logic [7:0]  load, full, drain = '0;
    logic [3:0]  count;
    int          checks = 0, failures = 0;

    load_sched8 #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_addr_en(in_addr_en), .in_addr(in_addr),
        .load(load), .sel(sel), .data_out(data_out), .full(full),
        .drain(drain), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v, ae;
        logic [2:0] a;
        logic [15:0] d;
        logic [7:0] dr;
        logic rdy;
        logic [7:0] ld, fl;
        logic [3:0] cnt;
    } vec_t;

    typedef struct packed {
        logic [7:0] ld;
        logic [2:0] sel;
        logic [15:0] d;
    } exp_t;

    vec_t tbl[27];
    exp_t q[$];
    logic [7:0]  m_full = '0;
    logic [2:0]  m_ptr = '0, m_sel = '0;
    logic [15:0] m_data = '0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endtask

    function automatic logic [2:0] rr_model();
        for (int k = 0; k < 8; k++)
            if (!m_full[3'(m_ptr + 3'(k))]) return 3'(m_ptr + 3'(k));
        return m_ptr;
    endfunction

    task automatic step(input vec_t t);
        logic rdy_m, acc;
        logic [2:0] tgt;
        logic [7:0] set_m;
        exp_t e;
        @(negedge clk);
        in_valid = t.v; in_addr_en = t.ae; in_addr = t.a; in_data = t.d; drain = t.dr;
        #1;
        chk("in_ready", in_ready, t.rdy);
        rdy_m = t.ae ? !m_full[t.a] : (m_full != 8'hFF);
        acc   = t.v && rdy_m;
        tgt   = t.ae ? t.a : rr_model();
        set_m = acc ? 8'h01 << tgt : 8'h00;
        if (acc) begin
            q.push_back('{ld: set_m, sel: tgt, d: t.d});
            if (!t.ae) m_ptr = tgt + 3'd1;
        end
        m_full = (m_full & ~t.dr) | set_m;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            m_sel = e.sel;
            m_data = e.d;
            chk("sb_load", load, e.ld);
        end else chk("sb_idle_load", load, 8'h00);
        chk("sel", sel, m_sel);
        chk("data_out", data_out, m_data);
        chk("load", load, t.ld);
        chk("full", full, t.fl);
        chk("count", count, t.cnt);
    endtask

    initial begin
        tbl[0]  = '{1,0,0,16'h1111,8'h00,1,8'h01,8'h01,4'd1};
        tbl[1]  = '{1,0,0,16'h2222,8'h00,1,8'h02,8'h03,4'd2};
        tbl[2]  = '{1,0,0,16'h3333,8'h00,1,8'h04,8'h07,4'd3};
        tbl[3]  = '{1,0,0,16'h4444,8'h00,1,8'h08,8'h0F,4'd4};
        tbl[4]  = '{1,0,0,16'h5555,8'h00,1,8'h10,8'h1F,4'd5};
        tbl[5]  = '{1,0,0,16'h6666,8'h00,1,8'h20,8'h3F,4'd6};
        tbl[6]  = '{1,0,0,16'h7777,8'h00,1,8'h40,8'h7F,4'd7};
        tbl[7]  = '{1,0,0,16'h8888,8'h00,1,8'h80,8'hFF,4'd8};
        tbl[8]  = '{1,0,0,16'h9999,8'h00,0,8'h00,8'hFF,4'd8};
        tbl[9]  = '{0,0,0,16'h0000,8'h20,0,8'h00,8'hDF,4'd7};
        tbl[10] = '{1,0,0,16'hAAAA,8'h00,1,8'h20,8'hFF,4'd8};
        tbl[11] = '{1,1,6,16'h1234,8'h00,0,8'h00,8'hFF,4'd8};
        tbl[12] = '{0,1,6,16'h0000,8'h40,0,8'h00,8'hBF,4'd7};
        tbl[13] = '{1,1,6,16'hBEEF,8'h00,1,8'h40,8'hFF,4'd8};
        tbl[14] = '{0,0,0,16'h0000,8'hA0,0,8'h00,8'h5F,4'd6};
        tbl[15] = '{1,0,0,16'hC0DE,8'h00,1,8'h80,8'hDF,4'd7};
        tbl[16] = '{1,0,0,16'h5555,8'h00,1,8'h20,8'hFF,4'd8};
        tbl[17] = '{0,0,0,16'h0000,8'h41,0,8'h00,8'hBE,4'd6};
        tbl[18] = '{1,0,0,16'h6666,8'h00,1,8'h40,8'hFE,4'd7};
        tbl[19] = '{1,0,0,16'h0A0A,8'h00,1,8'h01,8'hFF,4'd8};
        tbl[20] = '{0,0,0,16'h0000,8'h05,0,8'h00,8'hFA,4'd6};
        tbl[21] = '{1,0,0,16'h1212,8'h00,1,8'h04,8'hFE,4'd7};
        tbl[22] = '{0,0,0,16'h0000,8'h04,1,8'h00,8'hFA,4'd6};
        tbl[23] = '{1,1,2,16'h2424,8'h10,1,8'h04,8'hEE,4'd6};
        tbl[24] = '{1,1,0,16'h7777,8'h00,1,8'h01,8'hEF,4'd7};
        tbl[25] = '{0,0,0,16'h0000,8'h00,1,8'h00,8'hEF,4'd7};
        tbl[26] = '{0,0,0,16'h0000,8'h10,1,8'h00,8'hEF,4'd7};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_load", load, 8'h00);
        chk("rst_full", full, 8'h00);
        chk("rst_count", count, 4'd0);
        chk("rst_sel", sel, 3'd0);
        chk("rst_data", data_out, 16'h0000);
        chk("rst_ready", in_ready, 1'b1);
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < 27; i++) step(tbl[i]);

        // async reset right after an accept edge must kill the strobe at once
        @(negedge clk);
        in_valid = 1; in_addr_en = 0; in_data = 16'hABCD; drain = '0;
        @(posedge clk);
        #1;
        chk("pre_rst_load", load, 8'h10);
        chk("pre_rst_data", data_out, 16'hABCD);
        #1 reset = 1;
        #1;
        chk("async_load", load, 8'h00);
        chk("async_full", full, 8'h00);
        chk("async_count", count, 4'd0);
        chk("async_sel", sel, 3'd0);
        chk("async_data", data_out, 16'h0000);
        @(negedge clk);
        reset = 0; in_valid = 1; in_data = 16'hF00D;
        @(posedge clk);
        #1;
        chk("post_rst_load", load, 8'h01);
        chk("post_rst_sel", sel, 3'd0);
        chk("post_rst_data", data_out, 16'hF00D);
        chk("post_rst_full", full, 8'h01);
        chk("post_rst_count", count, 4'd1);
        @(negedge clk);
        in_valid = 0;
        @(posedge clk);
        #1;
        chk("strobe_1cyc", load, 8'h00);
        chk("sb_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
